sim_status_monitor: RTL

- Simulation-side MMIO monitor between the multicycle RV32I CPU data-memory bus and the testbench.
- Snoops CPU stores to decide end-of-test: a tohost pass/fail word, or a watchdog timeout.
- Buffers console characters written by the program for the bench to drain.
- Exposes cycle and retired-instruction counters, so the bench ends on `done` instead of a fixed delay.

---
 rtl/sim_status_monitor_pkg.sv | 27 ++
 rtl/sim_status_monitor_if.sv | 39 +++
 rtl/sim_status_monitor_console_fifo.sv | 59 +++++
 rtl/sim_status_monitor.sv | 111 +++++++++++
 4 files changed

// File: rtl/sim_status_monitor_pkg.sv
// ============================================================================
// Module  : sim_status_pkg
// Brief   : Shared types and constants for the simulation status monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sim_status_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DONE    = 2'd1,
      ST_TIMEOUT = 2'd2
   } state_t;

   localparam logic [31:0] DEFAULT_TOHOST_ADDR  = 32'h0000_0FF0;
   localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h0000_0FF4;
   localparam logic [31:0] TIMEOUT_RESULT       = 32'hFFFF_FFFF;

   // A tohost word with bit 0 set ends the test; the remaining bits carry the fail code.
   function automatic logic [31:0] fail_code(input logic [31:0] wdata);
      return wdata >> 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sim_status_monitor_if.sv
// ============================================================================
// Module  : sim_status_if
// Brief   : CPU store snoop, status and console signals of the status monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sim_status_if;

   logic        mem_wren;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        instr_retire;
   logic        done;
   logic        pass;
   logic        timeout;
   logic [31:0] result_code;
   logic [31:0] cycle_count;
   logic [31:0] instret_count;
   logic        console_valid;
   logic [7:0]  console_data;
   logic        console_ready;
   logic        console_overflow;

   modport master (
      output mem_wren, mem_addr, mem_wdata, instr_retire, console_ready,
      input  done, pass, timeout, result_code, cycle_count, instret_count,
      input  console_valid, console_data, console_overflow
   );

   modport slave (
      input  mem_wren, mem_addr, mem_wdata, instr_retire, console_ready,
      output done, pass, timeout, result_code, cycle_count, instret_count,
      output console_valid, console_data, console_overflow
   );

endinterface

`default_nettype wire

// File: rtl/sim_status_monitor_console_fifo.sv
// ============================================================================
// Module  : console_fifo
// Brief   : Synchronous FIFO with an extra pointer bit for full/empty detection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module console_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = pop && !w_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
   assign w_push  = push && (!full || w_pop);

   assign valid = !w_empty;
   assign data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sim_status_monitor.sv
// ============================================================================
// Module  : sim_status_monitor
// Brief   : Snoops CPU stores for tohost/console MMIO, runs a watchdog and counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_status_monitor
   import sim_status_pkg::*;
#(
   parameter logic [31:0] TOHOST_ADDR    = DEFAULT_TOHOST_ADDR,
   parameter logic [31:0] CONSOLE_ADDR   = DEFAULT_CONSOLE_ADDR,
   parameter int          TIMEOUT_CYCLES = 4096,
   parameter int          FIFO_DEPTH     = 8
) (
   input  logic     clk,
   input  logic     reset,
   sim_status_if.slave bus
);

   localparam logic [31:0] C_WD_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_next_state;
   logic        r_pass;
   logic        w_next_pass;
   logic [31:0] r_result;
   logic [31:0] w_next_result;
   logic [31:0] r_cycle_count;
   logic [31:0] r_instret_count;
   logic        r_overflow;
   logic        w_run;
   logic        w_tohost_term;
   logic        w_console_push;
   logic        w_fifo_valid;
   logic        w_fifo_full;
   logic        w_fifo_pop;

   assign w_run          = (r_state == ST_RUN);
   assign w_tohost_term  = w_run && bus.mem_wren && (bus.mem_addr == TOHOST_ADDR) &&
                           bus.mem_wdata[0];
   assign w_console_push = w_run && bus.mem_wren && (bus.mem_addr == CONSOLE_ADDR);
   assign w_fifo_pop     = w_fifo_valid && bus.console_ready;

   always_comb begin
      w_next_state  = r_state;
      w_next_pass   = r_pass;
      w_next_result = r_result;
      case (r_state)
         ST_RUN: begin
            // A terminating store beats the watchdog in the same cycle.
            if (w_tohost_term) begin
               w_next_state  = ST_DONE;
               w_next_pass   = (bus.mem_wdata == 32'd1);
               w_next_result = (bus.mem_wdata == 32'd1) ? 32'd0 : fail_code(bus.mem_wdata);
            end else if (r_cycle_count == C_WD_LAST) begin
               w_next_state  = ST_TIMEOUT;
               w_next_pass   = 1'b0;
               w_next_result = TIMEOUT_RESULT;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= ST_RUN;
         r_pass          <= 1'b0;
         r_result        <= '0;
         r_cycle_count   <= '0;
         r_instret_count <= '0;
         r_overflow      <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_pass   <= w_next_pass;
         r_result <= w_next_result;
         if (w_run) begin
            r_cycle_count <= r_cycle_count + 32'd1;
            if (bus.instr_retire) r_instret_count <= r_instret_count + 32'd1;
         end
         if (w_console_push && w_fifo_full && !w_fifo_pop) r_overflow <= 1'b1;
      end
   end

   console_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_console_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (w_console_push),
      .push_data (bus.mem_wdata[7:0]),
      .pop       (w_fifo_pop),
      .valid     (w_fifo_valid),
      .data      (bus.console_data),
      .full      (w_fifo_full)
   );

   assign bus.done             = !w_run;
   assign bus.pass             = r_pass;
   assign bus.timeout          = (r_state == ST_TIMEOUT);
   assign bus.result_code      = r_result;
   assign bus.cycle_count      = r_cycle_count;
   assign bus.instret_count    = r_instret_count;
   assign bus.console_valid    = w_fifo_valid;
   assign bus.console_overflow = r_overflow;

endmodule

`default_nettype wire
